// File: rtl/exc_sched.sv
// M-stage exception/interrupt/ERET scheduler: decides a take, kills M, then
// sequences a one-cycle flush+redirect with a CP0 pulse and a settle guard.
module exc_sched #(
    parameter logic [31:0] HANDLER_PC   = 32'h0000_4180,
    parameter int          GUARD_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_M,
    input  logic [6:2]  ExcCode_M,
    input  logic        BD_M,
    input  logic [31:0] PC_M,
    input  logic        eret_M,
    input  logic [7:2]  HWInt,
    input  logic [7:2]  IM,
    input  logic        IE,
    input  logic        EXL,
    input  logic [31:0] EPC_cp0,
    output logic        kill_M,
    output logic        ExcReq,
    output logic        EretReq,
    output logic [6:2]  ExcCode_out,
    output logic        BD_out,
    output logic [31:0] EPC_out,
    output logic        flush,
    output logic        redirect,
    output logic [31:0] redirect_PC,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, FLUSH, GUARD} state_t;

    localparam logic [3:0] GUARD_LOAD = 4'(GUARD_CYCLES - 1);

    state_t     state, state_nxt;
    logic [3:0] guard_cnt;
    logic       is_eret;
    logic       int_hit, exc_hit, take_trap, take_eret;

    // A delay-slot instruction restarts at its branch, one word earlier.
    function automatic logic [31:0] epc_of(input logic bd, input logic [31:0] pc);
        return bd ? pc - 32'd4 : pc;
    endfunction

    assign int_hit   = IE & ~EXL & (|(HWInt & IM));
    assign exc_hit   = (ExcCode_M != 5'd0) & ~EXL;
    assign take_trap = valid_M & (int_hit | exc_hit);
    assign take_eret = valid_M & eret_M & ~take_trap;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (take_trap || take_eret) state_nxt = FLUSH;
            FLUSH:   state_nxt = GUARD;
            GUARD:   if (guard_cnt == 4'd0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        kill_M   = 1'b0;
        flush    = 1'b0;
        redirect = 1'b0;
        ExcReq   = 1'b0;
        EretReq  = 1'b0;
        busy     = (state != IDLE);
        case (state)
            IDLE: kill_M = take_trap | take_eret;
            FLUSH: begin
                flush    = 1'b1;
                redirect = 1'b1;
                ExcReq   = ~is_eret;
                EretReq  = is_eret;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            guard_cnt <= 4'd0;
        end else if (state == FLUSH) begin
            guard_cnt <= GUARD_LOAD;
        end else if (state == GUARD && guard_cnt != 4'd0) begin
            guard_cnt <= guard_cnt - 4'd1;
        end
    end

    // Take latches: only written on an accepted take in IDLE, held otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ExcCode_out <= 5'd0;
            BD_out      <= 1'b0;
            EPC_out     <= 32'd0;
            redirect_PC <= HANDLER_PC;
            is_eret     <= 1'b0;
        end else if (state == IDLE) begin
            if (take_trap) begin
                ExcCode_out <= int_hit ? 5'd0 : ExcCode_M;
                BD_out      <= BD_M;
                EPC_out     <= epc_of(BD_M, PC_M);
                redirect_PC <= HANDLER_PC;
                is_eret     <= 1'b0;
            end else if (take_eret) begin
                redirect_PC <= EPC_cp0;
                is_eret     <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_exc_sched.sv
// Directed bench for exc_sched: traps, interrupts, ERET, priority and reset.
module tb_exc_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_M;
    logic [6:2]  ExcCode_M;
    logic        BD_M;
    logic [31:0] PC_M;
    logic        eret_M;
    logic [7:2]  HWInt;
    logic [7:2]  IM;
    logic        IE;
    logic        EXL;
    logic [31:0] EPC_cp0;
    logic        kill_M, ExcReq, EretReq, BD_out, flush, redirect, busy;
    logic [6:2]  ExcCode_out;
    logic [31:0] EPC_out, redirect_PC;

    int checks = 0;
    int errors = 0;
    int pulses;

    exc_sched #(.HANDLER_PC(32'h0000_4180), .GUARD_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .valid_M(valid_M), .ExcCode_M(ExcCode_M),
        .BD_M(BD_M), .PC_M(PC_M), .eret_M(eret_M), .HWInt(HWInt), .IM(IM),
        .IE(IE), .EXL(EXL), .EPC_cp0(EPC_cp0), .kill_M(kill_M), .ExcReq(ExcReq),
        .EretReq(EretReq), .ExcCode_out(ExcCode_out), .BD_out(BD_out),
        .EPC_out(EPC_out), .flush(flush), .redirect(redirect),
        .redirect_PC(redirect_PC), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        valid_M = 1'b0; ExcCode_M = 5'd0; BD_M = 1'b0; PC_M = 32'd0;
        eret_M = 1'b0; HWInt = 6'd0; IM = 6'd0; IE = 1'b0; EXL = 1'b0;
        EPC_cp0 = 32'd0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 10) begin
            tick();
            n++;
        end
        chk(tag, busy, 1'b0);
    endtask

    initial begin
        quiet();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_flush", flush, 0);
        chk("rst_excreq", ExcReq, 0);
        chk("rst_kill", kill_M, 0);
        chk("rst_rpc", redirect_PC, 32'h4180);
        chk("rst_epc", EPC_out, 0);
        chk("rst_code", ExcCode_out, 0);

        // Overflow trap, not in delay slot
        valid_M = 1; ExcCode_M = 5'd12; PC_M = 32'h3010; #1;
        chk("ov_kill_T", kill_M, 1);
        chk("ov_excreq_T", ExcReq, 0);
        tick();
        chk("ov_excreq", ExcReq, 1);
        chk("ov_eretreq", EretReq, 0);
        chk("ov_flush", flush, 1);
        chk("ov_redirect", redirect, 1);
        chk("ov_rpc", redirect_PC, 32'h4180);
        chk("ov_epc", EPC_out, 32'h3010);
        chk("ov_code", ExcCode_out, 12);
        chk("ov_bd", BD_out, 0);
        chk("ov_busy_f", busy, 1);
        chk("ov_kill_f", kill_M, 0);
        tick();
        chk("ov_g1_busy", busy, 1);
        chk("ov_g1_flush", flush, 0);
        chk("ov_g1_excreq", ExcReq, 0);
        chk("ov_g1_kill", kill_M, 0);
        tick();
        chk("ov_g2_busy", busy, 1);
        chk("ov_g2_kill", kill_M, 0);
        tick();
        chk("ov_idle_busy", busy, 0);
        chk("ov_reeval_kill", kill_M, 1);
        valid_M = 0; ExcCode_M = 0; #1;
        chk("ov_bubble_kill", kill_M, 0);

        // Same trap in a delay slot, plus PC wrap-around
        valid_M = 1; ExcCode_M = 5'd12; BD_M = 1; PC_M = 32'h3014;
        tick();
        chk("bd_epc", EPC_out, 32'h3010);
        chk("bd_bd", BD_out, 1);
        quiet();
        wait_idle("bd_idle");
        valid_M = 1; ExcCode_M = 5'd10; BD_M = 1; PC_M = 32'h0;
        tick();
        chk("wrap_epc", EPC_out, 32'hFFFF_FFFC);
        chk("wrap_code", ExcCode_out, 10);
        quiet();
        wait_idle("wrap_idle");

        // Interrupt together with AdEL: interrupt wins, single ExcReq
        valid_M = 1; ExcCode_M = 5'd4; HWInt = 6'b000001; IM = 6'b000001; IE = 1;
        PC_M = 32'h3020; #1;
        chk("int_kill", kill_M, 1);
        tick();
        chk("int_excreq", ExcReq, 1);
        chk("int_code", ExcCode_out, 0);
        chk("int_epc", EPC_out, 32'h3020);
        EXL = 1;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (ExcReq) pulses++;
        end
        chk("int_single", pulses, 0);
        quiet();
        wait_idle("int_idle");

        // Interrupt pending under bubbles: take only when M is valid
        HWInt = 6'b000001; IM = 6'b000001; IE = 1; PC_M = 32'h3040;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (kill_M) pulses++;
            tick();
            if (ExcReq || busy) pulses++;
        end
        chk("bub_nokill", pulses, 0);
        valid_M = 1; #1;
        chk("bub_kill", kill_M, 1);
        tick();
        chk("bub_excreq", ExcReq, 1);
        chk("bub_epc", EPC_out, 32'h3040);
        quiet();
        wait_idle("bub_idle");

        // Exception + ERET together: trap wins
        valid_M = 1; ExcCode_M = 5'd8; eret_M = 1; EPC_cp0 = 32'h5000; PC_M = 32'h3050;
        tick();
        chk("exe_excreq", ExcReq, 1);
        chk("exe_eretreq", EretReq, 0);
        chk("exe_rpc", redirect_PC, 32'h4180);
        quiet();
        wait_idle("exe_idle");

        // ERET with interrupt held and EXL=1: no further take
        valid_M = 1; eret_M = 1; EPC_cp0 = 32'h3400; EXL = 1;
        HWInt = 6'b000001; IM = 6'b000001; IE = 1; #1;
        chk("eret_kill", kill_M, 1);
        tick();
        chk("eret_eretreq", EretReq, 1);
        chk("eret_excreq", ExcReq, 0);
        chk("eret_rpc", redirect_PC, 32'h3400);
        chk("eret_epc_hold", EPC_out, 32'h3050);
        chk("eret_code_hold", ExcCode_out, 8);
        eret_M = 0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (kill_M || ExcReq || EretReq) pulses++;
        end
        chk("eret_no_retake", pulses, 0);
        chk("eret_idle", busy, 0);
        quiet();

        // Reset during GUARD
        valid_M = 1; ExcCode_M = 5'd12; PC_M = 32'h3060; BD_M = 1;
        tick();
        chk("rg_excreq", ExcReq, 1);
        quiet();
        tick();
        chk("rg_in_guard", busy, 1);
        #2 reset = 1; #1;
        chk("rg_busy", busy, 0);
        chk("rg_flush", flush, 0);
        chk("rg_excreq0", ExcReq, 0);
        chk("rg_epc", EPC_out, 0);
        chk("rg_bd", BD_out, 0);
        chk("rg_code", ExcCode_out, 0);
        chk("rg_rpc", redirect_PC, 32'h4180);
        tick();
        reset = 0;
        valid_M = 1; ExcCode_M = 5'd5; PC_M = 32'h3070; #1;
        chk("rg_kill_after", kill_M, 1);
        tick();
        chk("rg_excreq_after", ExcReq, 1);
        chk("rg_code_after", ExcCode_out, 5);
        chk("rg_epc_after", EPC_out, 32'h3070);
        quiet();
        wait_idle("rg_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/exc_sched.md
# exc_sched

Pipeline exception scheduler for the five-stage MIPS core. It watches the M-stage exception fields carried down by the per-stage exception registers (code, EXL, branch-delay flag), together with hardware interrupt lines and ERET. It decides when a trap or return is taken, kills the M-stage instruction, and sequences a one-cycle pipeline flush plus PC redirect. It also issues a single write pulse to CP0 and then guards against re-triggering until CP0 state has settled.

## Interface
Parameters:
- HANDLER_PC, 32'h0000_4180, trap handler entry address
- GUARD_CYCLES, 2, cycles after a redirect during which no new take is evaluated (1..15)

Ports:
- clk  input  1  system clock, all state updates on posedge
- reset  input  1  asynchronous, active-high; clears all state immediately
- valid_M  input  1  M stage holds a real (non-bubble) instruction
- ExcCode_M  input  [6:2]  exception code of M instruction, 0 = none
- BD_M  input  1  M instruction sits in a branch delay slot
- PC_M  input  32  PC of M instruction
- eret_M  input  1  M instruction is ERET
- HWInt  input  [7:2]  hardware interrupt lines, level-sensitive
- IM  input  [7:2]  CP0 Status interrupt mask
- IE  input  1  CP0 Status global interrupt enable
- EXL  input  1  CP0 Status exception level
- EPC_cp0  input  32  current CP0 EPC, ERET target
- kill_M  output  1  combinational; suppress all M-stage side effects this cycle
- ExcReq  output  1  one-cycle pulse; CP0 writes Cause/EPC/BD and sets EXL
- EretReq  output  1  one-cycle pulse; CP0 clears EXL
- ExcCode_out  output  [6:2]  code for Cause (0 for interrupt)
- BD_out  output  1  BD for Cause
- EPC_out  output  32  value for EPC
- flush  output  1  clear F/D, D/E, E/M pipeline registers
- redirect  output  1  load redirect_PC into PC next edge
- redirect_PC  output  32  HANDLER_PC or latched ERET target
- busy  output  1  high whenever state is not IDLE

## Operation
- int_hit = IE & ~EXL & |(HWInt & IM).
- exc_hit = (ExcCode_M != 0) & ~EXL.
- Evaluation happens only in IDLE with valid_M=1. Bubbles never take; interrupts wait for a valid instruction in M.
- Priority: int_hit > exc_hit > eret_M.
- take_trap = valid_M & (int_hit | exc_hit).
- take_eret = valid_M & eret_M & ~take_trap.
- kill_M = IDLE & (take_trap | take_eret), combinational.
- On take_trap, latch:
  - ExcCode_out = int_hit ? 0 : ExcCode_M
  - BD_out = BD_M
  - EPC_out = BD_M ? PC_M - 4 : PC_M, 32-bit wrap-around
  - redirect_PC = HANDLER_PC
- On take_eret, latch redirect_PC = EPC_cp0 and set an internal is_eret flag. ExcCode_out, BD_out and EPC_out hold their previous values.
- States: IDLE, FLUSH, GUARD.
  - IDLE -> FLUSH on take_trap or take_eret, otherwise stay.
  - FLUSH lasts exactly 1 cycle:
    - flush=1, redirect=1
    - ExcReq=~is_eret, EretReq=is_eret
    - loads guard counter with GUARD_CYCLES-1
    - -> GUARD
  - GUARD: counter decrements each cycle; all inputs are ignored; -> IDLE when counter=0 in that cycle.
- In FLUSH and GUARD: kill_M=0, and HWInt/eret_M changes are not latched.
- An interrupt still asserted after GUARD is evaluated normally. EXL is 1 by then, so it is blocked until ERET clears EXL.

## Timing
- Reset values: state=IDLE, ExcCode_out=0, BD_out=0, EPC_out=0, redirect_PC=HANDLER_PC, is_eret=0, counter=0, and every pulse output and busy = 0.
- Reset is asynchronous. Assertion mid-FLUSH or mid-GUARD returns to IDLE at once, with no ExcReq/EretReq emitted.
- Cycle T: take detected, kill_M=1.
- Cycle T+1: FLUSH; flush, redirect, ExcReq/EretReq high for exactly this cycle; latched outputs valid.
- Cycles T+2 .. T+1+GUARD_CYCLES: GUARD, busy=1.
- First new evaluation happens at T+2+GUARD_CYCLES.
- busy is high from T+1 through the last GUARD cycle.
- ExcCode_out, BD_out, EPC_out and redirect_PC are stable from T+1 until the next take.
- Simultaneous events:
  - int_hit + exc_hit + eret_M in the same cycle: interrupt wins; ExcCode_out=0, and EPC_out is the M PC rule above.
  - exc_hit + eret_M: trap wins, no EretReq.

## Test plan
- ExcCode_M=12 (Ov), PC_M=0x3010, BD_M=0, valid_M=1, EXL=0 -> required: kill_M=1 at T; at T+1 ExcReq=1, flush=1, redirect_PC=0x4180, EPC_out=0x3010, ExcCode_out=12; busy deasserts after 2 guard cycles.
- Same trap with BD_M=1, PC_M=0x3014 -> required: EPC_out=0x3010, BD_out=1.
- HWInt[2]=1, IM[2]=1, IE=1, with ExcCode_M=4 (AdEL) in M simultaneously -> required: ExcCode_out=0, single ExcReq.
- HWInt asserted while valid_M=0 for 3 cycles, then valid_M=1 -> required: take occurs only on the valid cycle, with no kill_M earlier.
- eret_M=1, EPC_cp0=0x3400 -> required: EretReq=1, ExcReq=0, redirect_PC=0x3400; an interrupt held high through GUARD with EXL=1 produces no further take.
- Assert reset during GUARD -> required: busy=0 immediately, all outputs at reset values, and the next trap is accepted on the first valid cycle after release.
